// File: rtl/pdm_pcm_decimator.sv
// PDM word to PCM decimator: popcount, boxcar sum over N words, centre/scale/saturate, show-ahead FIFO.
// Define PDM_DECIMATOR_DC_BLOCK_EN to insert a first-order DC blocker (one extra cycle) before the FIFO.
module pdm_pcm_decimator #(
    parameter int WORD_LENGTH      = 16,
    parameter int DECIMATION_WORDS = 16,
    parameter int GAIN_SHIFT       = 7,
    parameter int FIFO_DEPTH       = 4,
    parameter int DC_SHIFT         = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic                          enable_i,
    input  logic                          word_valid_i,
    input  logic [WORD_LENGTH-1:0]        word_i,
    output logic signed [15:0]            pcm_o,
    output logic                          pcm_valid_o,
    input  logic                          pcm_ready_i,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o
);
    localparam int POP_W      = $clog2(WORD_LENGTH + 1);
    localparam int FULL_SCALE = WORD_LENGTH * DECIMATION_WORDS;
    localparam int ACC_W      = $clog2(FULL_SCALE + 1);
    localparam int CNT_W      = $clog2(DECIMATION_WORDS);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int FILL_W     = PTR_W + 1;

    if (DECIMATION_WORDS < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2
        || DC_SHIFT < 1 || DC_SHIFT > 19) begin : g_bad_params
        $error("pdm_pcm_decimator: illegal parameter combination");
    end

    function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
        if (v > 20'sd32767)       return 16'sh7FFF;
        else if (v < -20'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    logic [POP_W-1:0] w_pop;
    logic [POP_W-1:0] r_pop;
    logic             r_pop_v;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] r_wcnt;
    logic [ACC_W-1:0] r_sum;
    logic             r_sum_v;

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < WORD_LENGTH; i++) begin
            w_pop = w_pop + POP_W'(word_i[i]);
        end
    end

    assign w_acc_next = r_acc + ACC_W'(r_pop);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pop   <= '0;
            r_pop_v <= 1'b0;
            r_acc   <= '0;
            r_wcnt  <= '0;
            r_sum   <= '0;
            r_sum_v <= 1'b0;
        end else if (!enable_i) begin
            r_pop_v <= 1'b0;
            r_acc   <= '0;
            r_wcnt  <= '0;
            r_sum_v <= 1'b0;
        end else begin
            r_pop_v <= word_valid_i;
            if (word_valid_i) r_pop <= w_pop;
            r_sum_v <= 1'b0;
            if (r_pop_v) begin
                // The Nth word goes straight into the latched sum, so the reload loses nothing.
                if (r_wcnt == CNT_W'(DECIMATION_WORDS - 1)) begin
                    r_sum   <= w_acc_next;
                    r_sum_v <= 1'b1;
                    r_acc   <= '0;
                    r_wcnt  <= '0;
                end else begin
                    r_acc   <= w_acc_next;
                    r_wcnt  <= r_wcnt + 1'b1;
                end
            end
        end
    end

    logic signed [31:0] w_c;
    logic signed [19:0] w_x;
    logic               w_push;
    logic signed [15:0] w_push_data;

    assign w_c = signed'(32'(r_sum)) * 32'sd2 - 32'(FULL_SCALE);
    assign w_x = 20'(w_c <<< GAIN_SHIFT);

`ifdef PDM_DECIMATOR_DC_BLOCK_EN
    logic signed [19:0] r_x_prev;
    logic signed [19:0] r_y;
    logic               r_y_v;
    logic signed [19:0] w_y_next;

    assign w_y_next = w_x - r_x_prev + r_y - (r_y >>> DC_SHIFT);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_x_prev <= '0;
            r_y      <= '0;
            r_y_v    <= 1'b0;
        end else if (!enable_i) begin
            r_x_prev <= '0;
            r_y      <= '0;
            r_y_v    <= 1'b0;
        end else begin
            r_y_v <= r_sum_v;
            if (r_sum_v) begin
                r_x_prev <= w_x;
                r_y      <= w_y_next;
            end
        end
    end

    assign w_push      = r_y_v;
    assign w_push_data = sat16(r_y);
`else
    assign w_push      = r_sum_v;
    assign w_push_data = sat16(w_x);
`endif

    logic signed [15:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr;
    logic [PTR_W-1:0]   r_rd;
    logic [FILL_W-1:0]  r_fill;
    logic               r_overrun;
    logic               w_fifo_pop;
    logic               w_full;
    logic               w_write;

    assign w_fifo_pop = pcm_valid_o && pcm_ready_i;
    assign w_full     = (r_fill == FILL_W'(FIFO_DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign w_write    = w_push && (!w_full || w_fifo_pop);

    always_ff @(posedge clock_i) begin
        if (w_write) r_mem[r_wr] <= w_push_data;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_write)    r_wr <= r_wr + 1'b1;
            if (w_fifo_pop) r_rd <= r_rd + 1'b1;
            if (w_push && !w_write) r_overrun <= 1'b1;
            case ({w_write, w_fifo_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign pcm_valid_o = (r_fill != '0);
    assign pcm_o       = pcm_valid_o ? r_mem[r_rd] : '0;
    assign overrun_o   = r_overrun;
    assign fill_o      = r_fill;

endmodule

// File: tb/tb_pdm_pcm_decimator.sv
// Scoreboard bench for pdm_pcm_decimator (default build): reference model pushes expected samples, monitor pops on handshake.
module tb_pdm_pcm_decimator;
    localparam int W = 16;
    localparam int N = 16;
    localparam int G = 7;

    logic               clock_i      = 1'b0;
    logic               reset_ni     = 1'b0;
    logic               enable_i     = 1'b0;
    logic               word_valid_i = 1'b0;
    logic [15:0]        word_i       = '0;
    logic signed [15:0] pcm_o;
    logic               pcm_valid_o;
    logic               pcm_ready_i  = 1'b0;
    logic               overrun_o;
    logic [2:0]         fill_o;

    pdm_pcm_decimator #(
        .WORD_LENGTH(W), .DECIMATION_WORDS(N), .GAIN_SHIFT(G), .FIFO_DEPTH(4), .DC_SHIFT(8)
    ) dut (
        .clock_i(clock_i), .reset_ni(reset_ni), .enable_i(enable_i),
        .word_valid_i(word_valid_i), .word_i(word_i),
        .pcm_o(pcm_o), .pcm_valid_o(pcm_valid_o), .pcm_ready_i(pcm_ready_i),
        .overrun_o(overrun_o), .fill_o(fill_o)
    );

    always #5 clock_i = ~clock_i;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int m_sum = 0;
    int m_cnt = 0;
    bit rnd_ready = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Boxcar of ones over N words, centred, gained, clamped to 16-bit signed.
    function automatic int ref_sample(input int ones);
        int v;
        v = (2 * ones - W * N) * (1 << G);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic model_clear();
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic send(input logic [15:0] w, input bit drop = 0);
        word_valid_i = 1'b1;
        word_i       = w;
        if (rnd_ready) pcm_ready_i = 1'($urandom_range(0, 1));
        step();
        if (enable_i) begin
            m_sum += $countones(w);
            m_cnt++;
            if (m_cnt == N) begin
                if (!drop) exp_q.push_back(ref_sample(m_sum));
                model_clear();
            end
        end
    endtask

    task automatic idle(input int n);
        word_valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_sample(input logic [15:0] w, input bit drop = 0);
        for (int i = 0; i < N; i++) send(w, drop);
    endtask

    task automatic drain(input string name);
        pcm_ready_i = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        step();
        chk({name, "_valid_low"}, int'(pcm_valid_o), 0);
        chk({name, "_fill_zero"}, int'(fill_o), 0);
    endtask

    // 16 full-scale words into an empty FIFO with ready low: valid must appear exactly at E+2.
    task automatic latency_check(input string name);
        pcm_ready_i = 1'b0;
        for (int i = 0; i < N - 1; i++) send(16'hFFFF);
        send(16'hFFFF);
        word_valid_i = 1'b0;
        step();
        chk({name, "_e1_valid"}, int'(pcm_valid_o), 0);
        step();
        chk({name, "_e2_valid"}, int'(pcm_valid_o), 1);
        chk({name, "_e2_fill"}, int'(fill_o), 1);
        chk({name, "_e2_pcm"}, int'(pcm_o), 32767);
        idle(3);
        chk({name, "_single"}, int'(fill_o), 1);
    endtask

    always @(negedge clock_i) begin
        if (reset_ni && pcm_valid_o && pcm_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got %0d expected none", pcm_o);
            end else begin
                chk("pcm_sample", int'(pcm_o), exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pats [5];
        pats = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'hFF00, 16'h5A5A};

        #2;
        chk("reset_valid", int'(pcm_valid_o), 0);
        chk("reset_fill", int'(fill_o), 0);
        chk("reset_pcm", int'(pcm_o), 0);
        chk("reset_overrun", int'(overrun_o), 0);
        step();
        step();
        reset_ni    = 1'b1;
        enable_i    = 1'b1;
        pcm_ready_i = 1'b1;
        step();

        foreach (pats[k]) begin
            send_sample(pats[k]);
            idle(3);
        end
        for (int i = 0; i < N - 1; i++) send(16'h00FF);
        send(16'hFFFF);
        idle(3);
        drain("patterns");

        // Fill the FIFO, then push and pop on the same edge.
        pcm_ready_i = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < N; i++) send(16'($urandom));
        idle(3);
        chk("full_fill", int'(fill_o), 4);
        chk("full_overrun", int'(overrun_o), 0);
        for (int i = 0; i < N; i++) send(16'($urandom));
        word_valid_i = 1'b0;
        step();
        pcm_ready_i = 1'b1;
        step();
        pcm_ready_i = 1'b0;
        chk("pushpop_fill", int'(fill_o), 4);
        chk("pushpop_overrun", int'(overrun_o), 0);
        idle(2);

        for (int i = 0; i < N; i++) send(16'($urandom), 1'b1);
        idle(3);
        chk("overrun_fill", int'(fill_o), 4);
        chk("overrun_flag", int'(overrun_o), 1);
        drain("overrun");
        chk("overrun_sticky", int'(overrun_o), 1);

        for (int i = 0; i < 7; i++) send(16'($urandom));
        enable_i = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) send(16'hFFFF);
        idle(2);
        enable_i = 1'b1;
        idle(1);
        chk("disable_no_sample", int'(fill_o), 0);
        latency_check("enable_lat");
        drain("enable");

        for (int i = 0; i < 7; i++) send(16'($urandom));
        word_valid_i = 1'b0;
        reset_ni = 1'b0;
        model_clear();
        #2;
        chk("midreset_overrun", int'(overrun_o), 0);
        chk("midreset_fill", int'(fill_o), 0);
        step();
        reset_ni = 1'b1;
        step();
        latency_check("reset_lat");
        drain("reset");

        rnd_ready = 1;
        for (int s = 0; s < 20; s++) begin
            for (int i = 0; i < N; i++) begin
                send(16'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rnd_ready = 0;
        idle(3);
        drain("random");
        chk("final_overrun", int'(overrun_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
